// File: rtl/ifetch_ctrl_if.sv
// Fetch-side bundle: instruction-memory request/response, redirect, decode handshake.
// Latency: none (wires only).
// Backpressure: carried by instr_ready_i toward the fetch unit.
// master = fetch unit side, slave = memory/execute/decode environment side.
interface ifetch_ctrl_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        misalign_o;

    modport master (
        output imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o, misalign_o,
        input  imem_rdata_i, redirect_i, redirect_pc_i, instr_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o, misalign_o,
        output imem_rdata_i, redirect_i, redirect_pc_i, instr_ready_i
    );
endinterface

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, reads a 1-cycle-latency imem, buffers words in a prefetch queue.
// Latency: request at T, data at T+1, instruction valid to decode at T+2; one instruction per cycle sustained.
// Backpressure: requests issue only while queue count + in-flight read fits QDEPTH, so a stalled decode loses nothing.
// Ports: clk_i/rst_ni (synchronous active-low reset); bus (master modport) carries imem request/response,
// redirect strobe + target, decode valid/ready handshake with head instruction/PC, and the misalign pulse.
module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2,
    parameter int          ADDR_W   = 11
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    ifetch_ctrl_if.master bus
);
    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = $clog2(QDEPTH + 1);

    typedef enum logic [1:0] {S_RESET, S_FETCH, S_HOLD} state_t;

    state_t r_state;
    state_t w_state_nxt;

    // PCs are held as word addresses; the byte offset is always zero.
    logic [29:0]      r_fetch_word;
    logic [29:0]      r_infl_word;
    logic             r_inflight;
    logic             r_misalign;
    logic [31:0]      r_q_dat [QDEPTH];
    logic [29:0]      r_q_word[QDEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_valid;
    logic             w_pop;
    logic             w_push;
    logic             w_credit;
    logic             w_req;
    logic [CNT_W:0]   w_occ;

    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid & bus.instr_ready_i;
    // A response arriving in a redirect cycle belongs to the old path and is dropped.
    assign w_push  = r_inflight & ~bus.redirect_i;

    // Occupancy after this cycle's pop, counting the read already in flight; a
    // push into a full queue is fine when the head leaves in the same cycle.
    assign w_occ    = {1'b0, r_count} - (CNT_W+1)'(w_pop) + (CNT_W+1)'(r_inflight);
    assign w_credit = (w_occ < (CNT_W+1)'(QDEPTH));

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= S_RESET;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (bus.redirect_i) begin
            w_state_nxt = S_FETCH;
        end else begin
            case (r_state)
                S_RESET:         w_state_nxt = S_FETCH;
                S_FETCH, S_HOLD: w_state_nxt = w_credit ? S_FETCH : S_HOLD;
                default:         w_state_nxt = S_RESET;
            endcase
        end
    end

    // Output logic
    always_comb begin
        w_req             = (r_state == S_FETCH) & w_credit & ~bus.redirect_i;
        bus.imem_req_o    = w_req;
        // Upper bits above the imem index pass through unchanged.
        bus.imem_addr_o   = {r_fetch_word[29:ADDR_W], r_fetch_word[ADDR_W-1:0], 2'b00};
        bus.instr_valid_o = w_valid;
        bus.instr_o       = w_valid ? r_q_dat[r_rd_ptr] : 32'h0;
        bus.instr_pc_o    = w_valid ? {r_q_word[r_rd_ptr], 2'b00} : 32'h0;
        bus.misalign_o    = r_misalign;
    end

    // Fetch PC, in-flight tracking and prefetch queue
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_fetch_word <= RESET_PC[31:2];
            r_infl_word  <= '0;
            r_inflight   <= 1'b0;
            r_misalign   <= 1'b0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                r_q_dat[i]  <= '0;
                r_q_word[i] <= '0;
            end
        end else begin
            r_inflight <= w_req;
            r_misalign <= 1'b0;
            if (w_req) begin
                r_infl_word  <= r_fetch_word;
                r_fetch_word <= r_fetch_word + 30'd1;
            end
            if (bus.redirect_i) begin
                // w_req is low here, so the PC load cannot collide with an increment.
                r_fetch_word <= bus.redirect_pc_i[31:2];
                r_misalign   <= |bus.redirect_pc_i[1:0];
                r_rd_ptr     <= '0;
                r_wr_ptr     <= '0;
                r_count      <= '0;
            end else begin
                if (w_push) begin
                    r_q_dat[r_wr_ptr]  <= bus.imem_rdata_i;
                    r_q_word[r_wr_ptr] <= r_infl_word;
                    r_wr_ptr           <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            end
        end
    end
endmodule

// File: tb/tb_ifetch_ctrl.sv
module tb_ifetch_ctrl;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          QDEPTH   = 2;
    localparam logic [31:0] KEY      = 32'hC0DE_0000;

    logic clk;
    logic rst_n;
    int   errs;
    int   checks;

    ifetch_ctrl_if bus();

    ifetch_ctrl #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH), .ADDR_W(11)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sampled DUT outputs for the current cycle
    logic        s_req, s_valid, s_mis;
    logic [31:0] s_addr, s_instr, s_pc;

    // Reference model: queue of delivered words plus abstract fetch state
    typedef struct {
        logic [31:0] pc;
        logic [31:0] dat;
    } ent_t;
    ent_t        m_q[$];
    logic        m_infl;
    logic [31:0] m_infl_pc;
    logic [31:0] m_pc;
    int          m_mode;   // 0 after reset, 1 fetching, 2 waiting for room
    logic        m_mis;
    logic        m_on;

    typedef struct {
        logic        rst_n;
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic        e_mis;
    } vec_t;
    vec_t tbl[19];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock cycle: sample outputs mid-cycle, compare to model, advance model,
    // then let the memory answer any request seen this cycle.
    task automatic tick();
        logic mv, mpop, mcred, mreq;
        int   occ;
        @(negedge clk);
        s_req   = bus.imem_req_o;
        s_addr  = bus.imem_addr_o;
        s_valid = bus.instr_valid_o;
        s_instr = bus.instr_o;
        s_pc    = bus.instr_pc_o;
        s_mis   = bus.misalign_o;

        mv    = (m_q.size() != 0);
        mpop  = mv && bus.instr_ready_i;
        occ   = m_q.size() - (mpop ? 1 : 0) + (m_infl ? 1 : 0);
        mcred = (occ < QDEPTH);
        mreq  = (m_mode == 1) && mcred && !bus.redirect_i;
        if (m_on) begin
            chk("model_req", 32'(s_req), 32'(mreq));
            chk("model_addr", s_addr, m_pc);
            chk("model_valid", 32'(s_valid), 32'(mv));
            chk("model_misalign", 32'(s_mis), 32'(m_mis));
            if (mv) begin
                chk("model_pc", s_pc, m_q[0].pc);
                chk("model_instr", s_instr, m_q[0].dat);
            end
        end

        if (!rst_n) begin
            m_q.delete();
            m_infl = 1'b0;
            m_pc   = RESET_PC;
            m_mode = 0;
            m_mis  = 1'b0;
        end else if (bus.redirect_i) begin
            m_q.delete();
            m_infl = 1'b0;
            m_pc   = bus.redirect_pc_i & ~32'h3;
            m_mis  = (bus.redirect_pc_i[1:0] != 2'b00);
            m_mode = 1;
        end else begin
            if (mpop) void'(m_q.pop_front());
            if (m_infl) m_q.push_back('{pc: m_infl_pc, dat: bus.imem_rdata_i});
            m_mis  = 1'b0;
            m_infl = mreq;
            if (mreq) begin
                m_infl_pc = m_pc;
                m_pc      = m_pc + 32'd4;
            end
            m_mode = (m_mode == 0) ? 1 : (mcred ? 1 : 2);
        end

        @(posedge clk);
        #1;
        bus.imem_rdata_i = s_req ? (s_addr ^ KEY) : $urandom;
    endtask

    initial begin
        logic [31:0] popped;
        errs   = 0;
        checks = 0;
        m_on   = 1'b0;
        m_q.delete();
        m_infl = 1'b0; m_infl_pc = '0; m_pc = RESET_PC; m_mode = 0; m_mis = 1'b0;

        rst_n             = 1'b0;
        bus.instr_ready_i = 1'b1;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 32'h0;
        bus.imem_rdata_i  = 32'h0;

        //         rst ready redir rpc        req addr         valid pc           mis
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h000, 1'b0, 32'h000, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h000, 1'b0, 32'h000, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h004, 1'b0, 32'h000, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h008, 1'b1, 32'h000, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h008, 1'b1, 32'h000, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h008, 1'b1, 32'h000, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h008, 1'b1, 32'h000, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h008, 1'b1, 32'h004, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h00C, 1'b0, 32'h000, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h010, 1'b1, 32'h008, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 32'h203, 1'b0, 32'h014, 1'b1, 32'h00C, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h000, 1'b1};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h204, 1'b0, 32'h000, 1'b0};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h208, 1'b1, 32'h200, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h20C, 1'b1, 32'h204, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 32'h20C, 1'b1, 32'h204, 1'b0};
        tbl[16] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h000, 1'b0};
        tbl[17] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h000, 1'b0};
        tbl[18] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h100, 1'b0};

        // Power-on reset; the second cycle shows the reset state
        #1;
        tick();
        m_on = 1'b1;
        tick();
        chk("reset_req", 32'(s_req), 32'h0);
        chk("reset_addr", s_addr, RESET_PC);
        chk("reset_valid", 32'(s_valid), 32'h0);
        chk("reset_misalign", 32'(s_mis), 32'h0);
        chk("reset_instr", s_instr, 32'h0);
        chk("reset_pc", s_pc, 32'h0);

        // Vector table: startup latency, full-queue stall, misaligned redirect, redirect with full queue
        for (int i = 0; i < 19; i++) begin
            rst_n             = tbl[i].rst_n;
            bus.instr_ready_i = tbl[i].ready;
            bus.redirect_i    = tbl[i].redir;
            bus.redirect_pc_i = tbl[i].rpc;
            tick();
            chk($sformatf("tbl%0d_req", i), 32'(s_req), 32'(tbl[i].e_req));
            chk($sformatf("tbl%0d_addr", i), s_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_valid", i), 32'(s_valid), 32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_misalign", i), 32'(s_mis), 32'(tbl[i].e_mis));
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d_pc", i), s_pc, tbl[i].e_pc);
                chk($sformatf("tbl%0d_instr", i), s_instr, tbl[i].e_pc ^ KEY);
            end
        end
        bus.redirect_i = 1'b0;

        // Mid-stream reset for one cycle, then restart with power-on latency
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("mrst_req", 32'(s_req), 32'h0);
        chk("mrst_addr", s_addr, RESET_PC);
        chk("mrst_valid", 32'(s_valid), 32'h0);
        chk("mrst_misalign", 32'(s_mis), 32'h0);
        chk("mrst_instr", s_instr, 32'h0);
        chk("mrst_pc", s_pc, 32'h0);
        tick();
        chk("mrst_req0", 32'(s_req), 32'h1);
        chk("mrst_addr0", s_addr, RESET_PC);
        tick();
        chk("mrst_addr1", s_addr, RESET_PC + 32'd4);
        tick();
        chk("mrst_valid0", 32'(s_valid), 32'h1);
        chk("mrst_pc0", s_pc, RESET_PC);
        tick();
        tick();

        // Redirect coinciding with a pop and a response arrival
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h300;
        tick();
        popped = s_pc;
        chk("rdpop_valid", 32'(s_valid), 32'h1);
        chk("rdpop_req", 32'(s_req), 32'h0);
        bus.redirect_i = 1'b0;
        tick();
        chk("rdpop_valid_r1", 32'(s_valid), 32'h0);
        chk("rdpop_addr_r1", s_addr, 32'h300);
        tick();
        chk("rdpop_valid_r2", 32'(s_valid), 32'h0);
        tick();
        chk("rdpop_valid_r3", 32'(s_valid), 32'h1);
        chk("rdpop_pc_r3", s_pc, 32'h300);
        if (s_pc == popped) begin
            errs++;
            $display("FAIL rdpop_dup: popped pc %h reappeared", popped);
        end

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst_n             = ($urandom_range(0, 199) != 0);
            bus.instr_ready_i = ($urandom_range(0, 3) != 0);
            bus.redirect_i    = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 9) == 0)
                bus.redirect_pc_i = 32'hFFFF_FFF0 | ($urandom & 32'h3);
            else
                bus.redirect_pc_i = $urandom & 32'h0000_0FFF;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
